reg_access_arbiter: RTL

Round-robin arbiter and sequencer that shares one WIDTH-bit storage register block between two requesters.

---
 rtl/reg_access_arbiter_if.sv | 69 ++++++
 rtl/reg_access_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_access_arbiter_if.sv
// ----------------------------------------------------------------------------
// reg_access_arbiter_if
//
// Bundles the two requester handshakes, the read-data return path and the
// storage-register drive/return signals of reg_access_arbiter.
//
// Handshake semantics (both requesters identical):
//   - A requester raises reqN with weN/wdataN valid and holds all three
//     steady until it observes gntN high. gntN is a one-cycle pulse in the
//     cycle the arbiter issues the access to the register.
//   - Dropping reqN before gntN withdraws the request; it is never granted.
//   - doneN is a one-cycle pulse when the access has completed. For a read,
//     rdata is valid in that cycle and is held until the next read completes.
//   - reqN still high after doneN counts as a fresh request.
//
// Modports:
//   slave  : the arbiter (consumes requests and reg_rdata, produces grants,
//            completions, read data and the register drive).
//   master : the surrounding environment (requesters plus storage register).
//
// Parameters:
//   WIDTH  : data width of the storage register and all data signals.
// ----------------------------------------------------------------------------
interface reg_access_arbiter_if #(
    parameter int WIDTH = 16
);

    // Requester 0
    logic             req0;
    logic             we0;
    logic [WIDTH-1:0] wdata0;

    // Requester 1
    logic             req1;
    logic             we1;
    logic [WIDTH-1:0] wdata1;

    // Grant / completion pulses and returned data
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] rdata;
    logic             busy;

    // Storage register drive and return
    logic             reg_rw;
    logic [WIDTH-1:0] reg_wdata;
    logic [WIDTH-1:0] reg_rdata;

    modport slave (
        input  req0, we0, wdata0,
        input  req1, we1, wdata1,
        input  reg_rdata,
        output gnt0, gnt1, done0, done1,
        output rdata, busy,
        output reg_rw, reg_wdata
    );

    modport master (
        output req0, we0, wdata0,
        output req1, we1, wdata1,
        output reg_rdata,
        input  gnt0, gnt1, done0, done1,
        input  rdata, busy,
        input  reg_rw, reg_wdata
    );

endinterface

// File: rtl/reg_access_arbiter.sv
// ----------------------------------------------------------------------------
// reg_access_arbiter
//
// Round-robin arbiter and sequencer sharing one WIDTH-bit storage register
// (ports: clk, reset, in, read_write, registered out) between two requesters.
// One access is in flight at a time. The arbiter drives the register's
// read_write/in, and for reads samples the register's out after READ_LAT
// cycles of waiting, returning it on rdata with a done pulse.
//
// Sequence per access:  IDLE -> ISSUE -> (WAIT x READ_LAT, reads only) -> RESP
//   - gnt<id> is high during ISSUE; reg_rw/reg_wdata carry the op there.
//   - done<id> is high during RESP.
//   - Outside ISSUE reg_rw=0 and reg_wdata=0, so the register idles in read.
//
// Ports:
//   clk        : system clock, all logic on posedge.
//   reset      : synchronous, active-high reset.
//   bus        : reg_access_arbiter_if.slave
//                  req0/we0/wdata0, req1/we1/wdata1  requester inputs
//                  gnt0/gnt1       one-cycle accept pulses
//                  done0/done1     one-cycle completion pulses
//                  rdata           last read result
//                  busy            high whenever not IDLE
//                  reg_rw          register read_write (1 = write)
//                  reg_wdata       register in
//                  reg_rdata       register out
//   state_dbg  : current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP).
//
// Parameters:
//   WIDTH      : data width (default 16).
//   READ_LAT   : WAIT cycles before reg_rdata is sampled (>= 1, default 1).
//
// Every output is a flop; the combinational process computes the value each
// output must take in the next cycle from the next state.
// ----------------------------------------------------------------------------
module reg_access_arbiter #(
    parameter int WIDTH    = 16,
    parameter int READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    reg_access_arbiter_if.slave   bus,
    output logic [1:0]            state_dbg
);

    // Wait counter holds READ_LAT-1 down to 0.
    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(READ_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state_q, state_n;

    // Latched transaction of the current winner.
    logic             id_q,    id_n;
    logic             we_q,    we_n;
    logic [WIDTH-1:0] wdata_q, wdata_n;

    // Requester granted most recently; resets to 1 so requester 0 wins
    // the first tie.
    logic             last_q,  last_n;

    logic [CW-1:0]    cnt_q,   cnt_n;

    // Registered outputs.
    logic             gnt0_q,  gnt0_n;
    logic             gnt1_q,  gnt1_n;
    logic             done0_q, done0_n;
    logic             done1_q, done1_n;
    logic [WIDTH-1:0] rdata_q, rdata_n;
    logic             busy_q,  busy_n;
    logic             rw_q,    rw_n;
    logic [WIDTH-1:0] wd_q,    wd_n;

    // Winner chosen in IDLE.
    logic             pick;
    logic             pick_we;
    logic [WIDTH-1:0] pick_wdata;

    // ------------------------------------------------------------------
    // Round-robin selection: a lone request wins outright; on a tie the
    // requester that was not granted last time wins.
    // ------------------------------------------------------------------
    always_comb begin
        pick = 1'b0;
        if (bus.req0 && bus.req1) begin
            pick = ~last_q;
        end else if (bus.req1) begin
            pick = 1'b1;
        end
        pick_we    = pick ? bus.we1    : bus.we0;
        pick_wdata = pick ? bus.wdata1 : bus.wdata0;
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state_q;
        id_n    = id_q;
        we_n    = we_q;
        wdata_n = wdata_q;
        last_n  = last_q;
        cnt_n   = cnt_q;
        rdata_n = rdata_q;
        gnt0_n  = 1'b0;
        gnt1_n  = 1'b0;
        done0_n = 1'b0;
        done1_n = 1'b0;
        rw_n    = 1'b0;
        wd_n    = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    id_n    = pick;
                    we_n    = pick_we;
                    wdata_n = pick_wdata;
                    last_n  = pick;
                    gnt0_n  = ~pick;
                    gnt1_n  = pick;
                    // ISSUE drives the register with the latched op.
                    rw_n    = pick_we;
                    wd_n    = pick_wdata;
                    state_n = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (we_q) begin
                    // The register captures the write at this edge.
                    done0_n = ~id_q;
                    done1_n = id_q;
                    state_n = S_RESP;
                end else begin
                    cnt_n   = WAIT_LOAD;
                    state_n = S_WAIT;
                end
            end

            S_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_n = bus.reg_rdata;
                    done0_n = ~id_q;
                    done1_n = id_q;
                    state_n = S_RESP;
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
            end

            S_RESP: begin
                // Requests seen here wait for IDLE, so accesses never overlap.
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

    // ------------------------------------------------------------------
    // State and output registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            rw_q    <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_n;
            id_q    <= id_n;
            we_q    <= we_n;
            wdata_q <= wdata_n;
            last_q  <= last_n;
            cnt_q   <= cnt_n;
            gnt0_q  <= gnt0_n;
            gnt1_q  <= gnt1_n;
            done0_q <= done0_n;
            done1_q <= done1_n;
            rdata_q <= rdata_n;
            busy_q  <= busy_n;
            rw_q    <= rw_n;
            wd_q    <= wd_n;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.reg_rw    = rw_q;
    assign bus.reg_wdata = wd_q;

    assign state_dbg     = state_q;

endmodule
